pmem_responder: RTL and testbench
=================================

Name: pmem_responder

Overview:
Synthesizable physical-memory responder for the NPC core's load/store port. It replaces the DPI pmem read/write path with an on-chip word array behind a valid/ready request channel and a valid/ready response channel. It has a programmable response latency. It services one outstanding request at a time and performs byte-lane alignment so the core can use rsp_rdata[7:0] / [15:0] directly for lb/lh/lbu/lhu.

Parameters:
ADDR_BASE, 32'h80000000, byte address mapped to word 0 of the array
DEPTH_LOG2, 12, log2 of array depth in 32-bit words (default 4096 words = 16 KiB)
LATENCY, 2, cycles from request accept to first rsp_valid; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_wen  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, byte 0 in bits [7:0]
req_wmask  input  4  store byte mask, bit i enables byte i (0001 = sb, 0011 = sh, 1111 = sw)
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts the response
rsp_rdata  output  32  load data, right-aligned; 0 for stores and errors
rsp_err  output  1  address out of range

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, latency counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Array contents are not reset.
- req_ready = (state==IDLE) && !reset. It is 1 in the first cycle after reset deasserts.
- FSM states:
  - IDLE: accept on req_valid && req_ready. Latch wen, addr[1:0], and rdata/err. Counter is loaded with LATENCY-1. If LATENCY==1, go to RESP; otherwise go to WAIT.
  - WAIT: counter decrements each cycle. When it reaches 0, go to RESP.
  - RESP: rsp_valid=1. On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid.
- Timing: the accept edge ends cycle 0; rsp_valid is first high in cycle LATENCY.
- Throughput with rsp_ready held at 1: one request per LATENCY+1 cycles. The responder never accepts a request in the same cycle as a response handshake.
- Address decode:
  - off = req_addr - ADDR_BASE (32-bit unsigned wrap).
  - In range iff off < 2^(DEPTH_LOG2+2); word index = off[DEPTH_LOG2+1:2].
  - Out of range (including any addr < ADDR_BASE, via wrap): rsp_err=1, rsp_rdata=0, no array write.
- Store, committed at the accept edge:
  - shift s = req_addr[1:0].
  - Effective mask = (req_wmask << s)[3:0] and effective data = req_wdata << 8s.
  - Lanes shifted past byte 3 are dropped.
  - Only masked bytes change; mask 0000 writes nothing but still produces a response.
  - Store response: rsp_rdata=0, rsp_err per decode.
- Load, array read at the accept edge:
  - rsp_rdata = word >> 8*req_addr[1:0], zero-filled in the upper bytes.
  - A load issued after a store response observes that store.
- Stability: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err are held and the FSM does not advance.
- Reset mid-operation:
  - A store accepted before reset remains committed.
  - A pending response (WAIT/RESP) is discarded and rsp_valid=0 after the reset edge.
- req_wdata, req_wmask and req_wen are ignored when no handshake occurs.

Test Plan:
- Reset, LATENCY=2; sw 0xDEADBEEF @0x80000010, mask 1111, rsp_ready=1. -> req_ready=0 in cycles 1-2; rsp_valid=1 in cycle 2 with rdata=0, err=0. A following lw @0x80000010 returns 0xDEADBEEF.
- Continue: sb 0x000000AA @0x80000011, mask 0001. -> lw @0x80000010 = 0xDEADAAEF; load @0x80000011 = 0x00DEADAA; load @0x80000012 = 0x0000DEAD.
- Backpressure: after lw, hold rsp_ready=0 for 5 cycles while req_valid=1. -> rsp_valid, rdata and err stay constant and req_ready=0. Releasing rsp_ready gives IDLE next cycle; the queued request is accepted then.
- Range: lw @0x7FFFFFFC and @0x80004000 (defaults). -> err=1, rdata=0. sw 0x12345678 @0x80004000 -> err=1, and lw @0x80000000 is unchanged.
- Reset in WAIT: sw 0xCAFEF00D @0x80000020, then assert reset one cycle after accept. -> rsp_valid=0 after reset, req_ready=1 the cycle after deassert; lw @0x80000020 returns 0xCAFEF00D.
- LATENCY=1 build with continuous req_valid and rsp_ready=1. -> accepts every 2nd cycle; each rsp_valid arrives exactly 1 cycle after its accept.

Source files
------------

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - on-chip word memory behind valid/ready load/store request and response channels
// One request in flight; response appears LATENCY cycles after accept (LATENCY legal range 1..15).
module pmem_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH];

    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            sh;
    logic [3:0]            wmask_eff;
    logic [31:0]           wdata_eff;
    logic                  accept;

    // Wrapping subtraction makes addresses below the base land far out of range.
    assign off       = req_addr - ADDR_BASE;
    assign in_range  = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign idx       = off[DEPTH_LOG2+1:2];
    assign sh        = req_addr[1:0];
    assign wmask_eff = req_wmask << sh;
    assign wdata_eff = req_wdata << {sh, 3'b000};

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        rdata_d = 32'd0;
        err_d   = !in_range;
        if (in_range && !req_wen) begin
            rdata_d = mem_q[idx] >> {sh, 3'b000};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Array is deliberately left out of reset so stores survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (accept && req_wen && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_eff[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_eff[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed and randomized checks of pmem_responder against a byte-level model
module tb_pmem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned SPAN = 1 << 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wmask;

    logic        req_valid1, req_ready1, req_wen1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
    logic [3:0]  req_wmask1;

    pmem_responder dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    pmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wmask(req_wmask1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference memory: byte-addressed by offset from BASE.
    bit [7:0] mb [int unsigned];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit m_inr(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < SPAN;
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] off;
        int unsigned wbase;
        int s;
        if (!m_inr(a)) return;
        off   = a - BASE;
        wbase = {off[31:2], 2'b00};
        s     = int'(a[1:0]);
        for (int i = 0; i < 4; i++) begin
            if (s + i < 4 && wm[i]) mb[wbase + s + i] = wd[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] r;
        int unsigned wbase;
        int s;
        r = 32'd0;
        if (!m_inr(a)) return r;
        off   = a - BASE;
        wbase = {off[31:2], 2'b00};
        s     = int'(a[1:0]);
        for (int lane = s; lane < 4; lane++) begin
            if (mb.exists(wbase + lane)) r[8*(lane-s) +: 8] = mb[wbase + lane];
            else r[8*(lane-s) +: 8] = 8'hxx;
        end
        return r;
    endfunction

    // Entered and left at #1 after a rising edge with the responder idle.
    task automatic txn(input bit wen, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                       input int bp, input string tag, output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_err;
        int n;
        exp_err = !m_inr(a);
        exp_rd  = wen ? 32'd0 : m_load(a);
        if (wen) m_store(a, wd, wm);
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = wm;
        rsp_ready = (bp == 0);
        chk1({tag, " ready"}, req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wen = 1'($urandom); req_wdata = $urandom; req_wmask = 4'($urandom); req_addr = $urandom;
        n = 1;
        while (!rsp_valid && n < 20) begin
            chk1({tag, " busy"}, req_ready, 1'b0);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd2);
        chk1({tag, " busy rsp"}, req_ready, 1'b0);
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        chk1({tag, " err"}, rsp_err, exp_err);
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk1({tag, " hold valid"}, rsp_valid, 1'b1);
            chk({tag, " hold rdata"}, rsp_rdata, exp_rd);
            chk1({tag, " hold err"}, rsp_err, exp_err);
            chk1({tag, " hold ready"}, req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk1({tag, " done valid"}, rsp_valid, 1'b0);
        chk1({tag, " done ready"}, req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] rd, rd0, exp_q;
        logic        er;
        logic        prev_acc;
        int          n, accepts;

        reset = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = BASE; req_wdata = 32'd0; req_wmask = 4'h0; rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_wen1 = 1'b0; req_addr1 = BASE; req_wdata1 = 32'd0; req_wmask1 = 4'h0; rsp_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst req_ready", req_ready, 1'b0);
        chk1("rst rsp_valid", rsp_valid, 1'b0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk1("rst rsp_err", rsp_err, 1'b0);
        reset = 1'b0;
        #1;
        chk1("post rst ready", req_ready, 1'b1);
        @(posedge clk); #1;

        for (int w = 0; w < 64; w++) txn(1'b1, BASE + 32'(4*w), $urandom, 4'hF, 0, "init", rd, er);

        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, "sw10", rd, er);
        chk("sw10 rdata0", rd, 32'd0);
        txn(1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, "lw10", rd, er);
        chk("lw10 const", rd, 32'hDEAD_BEEF);

        txn(1'b1, 32'h8000_0011, 32'h0000_00AA, 4'h1, 0, "sb11", rd, er);
        txn(1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, "lw10b", rd, er);
        chk("lw10b const", rd, 32'hDEAD_AAEF);
        txn(1'b0, 32'h8000_0011, 32'd0, 4'h0, 0, "ld11", rd, er);
        chk("ld11 const", rd, 32'h00DE_ADAA);
        txn(1'b0, 32'h8000_0012, 32'd0, 4'h0, 0, "ld12", rd, er);
        chk("ld12 const", rd, 32'h0000_DEAD);

        // Backpressure with a queued request waiting behind the stalled response.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
        @(posedge clk); #1;
        req_addr = 32'h8000_0012;
        n = 1;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp latency", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk1("bp valid", rsp_valid, 1'b1);
            chk("bp rdata", rsp_rdata, 32'hDEAD_AAEF);
            chk1("bp err", rsp_err, 1'b0);
            chk1("bp ready", req_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk1("bp idle ready", req_ready, 1'b1);
        chk1("bp idle valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk1("bp queued busy", req_ready, 1'b0);
        n = 1;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp queued latency", 32'(n), 32'd2);
        exp_q = m_load(32'h8000_0012);
        chk("bp queued rdata", rsp_rdata, exp_q);
        chk("bp queued const", rsp_rdata, 32'h0000_DEAD);
        @(posedge clk); #1;

        txn(1'b0, 32'h8000_0000, 32'd0, 4'h0, 0, "lw0 before", rd0, er);
        txn(1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 0, "lw low", rd, er);
        chk("lw low rdata", rd, 32'd0);
        chk1("lw low err", er, 1'b1);
        txn(1'b0, 32'h8000_4000, 32'd0, 4'h0, 0, "lw high", rd, er);
        chk("lw high rdata", rd, 32'd0);
        chk1("lw high err", er, 1'b1);
        txn(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 0, "sw high", rd, er);
        chk1("sw high err", er, 1'b1);
        txn(1'b0, 32'h8000_0000, 32'd0, 4'h0, 0, "lw0 after", rd, er);
        chk("lw0 unchanged", rd, rd0);

        // Reset while the store's response is still pending.
        m_store(32'h8000_0020, 32'hCAFE_F00D, 4'hF);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
        chk1("rstwait ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk1("rstwait valid", rsp_valid, 1'b0);
        chk1("rstwait ready after", req_ready, 1'b1);
        @(posedge clk); #1;
        txn(1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, "lw20", rd, er);
        chk("lw20 const", rd, 32'hCAFE_F00D);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = BASE + SPAN + 32'($urandom_range(0, 255));
            else if (sel == 1) a = BASE - 32'd1 - 32'($urandom_range(0, 15));
            else               a = BASE + 32'($urandom_range(0, 255));
            txn(1'($urandom), a, $urandom, 4'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                "rand", rd, er);
        end

        // LATENCY=1 instance under continuous requests.
        req_valid1 = 1'b1; req_wen1 = 1'b1; req_wmask1 = 4'hF; rsp_ready1 = 1'b1;
        prev_acc = 1'b0;
        accepts = 0;
        for (int c = 0; c < 16; c++) begin
            req_addr1  = BASE + 32'(4*c);
            req_wdata1 = $urandom;
            chk1("l1 valid", rsp_valid1, prev_acc);
            chk1("l1 ready", req_ready1, !prev_acc);
            if (rsp_valid1) begin
                chk("l1 rdata", rsp_rdata1, 32'd0);
                chk1("l1 err", rsp_err1, 1'b0);
            end
            prev_acc = req_ready1;
            if (req_ready1) accepts++;
            @(posedge clk); #1;
        end
        req_valid1 = 1'b0;
        chk("l1 accepts", 32'(accepts), 32'd8);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
